obj_dma_ctrl: RTL and testbench

- Sprite/object DMA sequencer, modelled on the arcade 8257 bus-request flow.
- On a trigger it requests the CPU bus, then block-copies LEN bytes from CPU work RAM (1024x8 synchronous BRAM, one-cycle read latency) into object RAM (512x8 dual-port BRAM).
- On completion it releases the bus.
- The top level uses O_GRANT to steer the work-RAM address/CE mux between CPU and DMA.

---
 rtl/dkong_dma_pkg.sv | 19 +
 rtl/dma_xfer_pipe.sv | 83 ++++++++
 rtl/obj_dma_ctrl.sv | 117 +++++++++++
 tb/tb_obj_dma_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dkong_dma_pkg.sv
// Shared types and defaults for the object-RAM DMA sequencer.
// The state enum is shared so that the FSM and any debug taps decode states the same way.
package dkong_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DRAIN,
        ST_DONE
    } dma_state_e;

    localparam int DMA_SRC_AW   = 10;
    localparam int DMA_DST_AW   = 9;
    localparam int DMA_LEN      = 384;
    localparam int DMA_DST_BASE = 0;
    localparam int OBJ_RAM_SIZE = 1 << DMA_DST_AW;

endpackage

// File: rtl/dma_xfer_pipe.sv
// Read-issue / write-back stage: one work-RAM read per rd_en, and the matching
// object-RAM write one cycle later, when the synchronous RAM data is valid.
module dma_xfer_pipe #(
    parameter int SRC_AW   = 10,
    parameter int DST_AW   = 9,
    parameter int CW       = 9,
    parameter int DST_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              rd_en,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [7:0]        src_q,
    output logic [CW-1:0]     rd_cnt,
    output logic              src_ce,
    output logic [SRC_AW-1:0] src_addr,
    output logic              dst_ce,
    output logic              dst_we,
    output logic [DST_AW-1:0] dst_addr,
    output logic [7:0]        dst_d
);

    logic [SRC_AW-1:0] base_q, base_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
    logic              pend_q, pend_d;
    logic [7:0]        dout_q, dout_d;
    logic [SRC_AW-1:0] src_sum;
    logic [DST_AW-1:0] dst_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            pend_q   <= 1'b0;
            dout_q   <= '0;
        end else begin
            base_q   <= base_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            pend_q   <= pend_d;
            dout_q   <= dout_d;
        end
    end

    always_comb begin
        base_d   = base_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        pend_d   = rd_en;
        dout_d   = dout_q;
        if (clr) begin
            base_d   = src_base;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            pend_d   = 1'b0;
        end else begin
            if (rd_en) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
            end
            if (pend_q) begin
                wr_cnt_d = wr_cnt_q + 1'b1;
                dout_d   = src_q;
            end
        end
    end

    // Truncating adds give the free-running modulo wrap on both address spaces.
    assign src_sum = base_q + SRC_AW'(rd_cnt_q);
    assign dst_sum = DST_AW'(DST_BASE) + DST_AW'(wr_cnt_q);

    assign rd_cnt   = rd_cnt_q;
    assign src_ce   = rd_en;
    assign src_addr = rd_en ? src_sum : '0;
    assign dst_ce   = pend_q;
    assign dst_we   = pend_q;
    assign dst_addr = pend_q ? dst_sum : '0;
    // Pass the RAM output straight through on a write, otherwise hold the last byte.
    assign dst_d    = pend_q ? src_q : dout_q;

endmodule

// File: rtl/obj_dma_ctrl.sv
// Sprite/object DMA sequencer: requests the CPU bus, block-copies LEN bytes from
// work RAM into object RAM at one byte per clock, then releases the bus.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for I_DMA_GO; base latched and counters cleared on accept
// ST_REQ   | BUSRQ held, waiting for BUSAK
// ST_XFER  | reads issued while granted and BUSAK high; pauses when BUSAK drops
// ST_DRAIN | last read issued, its object-RAM write completes here
// ST_DONE  | one-cycle completion pulse, bus released
module obj_dma_ctrl
    import dkong_dma_pkg::*;
#(
    parameter int SRC_AW   = DMA_SRC_AW,
    parameter int DST_AW   = DMA_DST_AW,
    parameter int LEN      = DMA_LEN,
    parameter int DST_BASE = DMA_DST_BASE
) (
    input  logic              I_CLK,
    input  logic              I_RST_n,
    input  logic              I_DMA_GO,
    input  logic [SRC_AW-1:0] I_SRC_BASE,
    input  logic              I_BUSAK,
    output logic              O_BUSRQ,
    output logic              O_GRANT,
    output logic [SRC_AW-1:0] O_SRC_ADDR,
    output logic              O_SRC_CE,
    input  logic [7:0]        I_SRC_Q,
    output logic [DST_AW-1:0] O_DST_ADDR,
    output logic [7:0]        O_DST_D,
    output logic              O_DST_CE,
    output logic              O_DST_WE,
    output logic              O_BUSY,
    output logic              O_DONE
);

    localparam int CW = $clog2(LEN + 1);

    dma_state_e    state_q, state_d;
    logic          grant_q, grant_d;
    logic          clr;
    logic          rd_en;
    logic [CW-1:0] rd_cnt;
    logic          last_rd;

    always_ff @(posedge I_CLK or negedge I_RST_n) begin
        if (!I_RST_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign last_rd = (rd_cnt == CW'(LEN - 1));

    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        clr     = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_DMA_GO) begin
                    clr     = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (I_BUSAK) begin
                    grant_d = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // BUSAK gates the read combinationally so a drop stops issue at once.
                rd_en   = grant_q & I_BUSAK;
                grant_d = I_BUSAK;
                if (rd_en && last_rd) begin
                    grant_d = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign O_GRANT = grant_q;
    assign O_BUSRQ = (state_q == ST_REQ) || (state_q == ST_XFER);
    assign O_BUSY  = (state_q == ST_REQ) || (state_q == ST_XFER) || (state_q == ST_DRAIN);
    assign O_DONE  = (state_q == ST_DONE);

    dma_xfer_pipe #(
        .SRC_AW   (SRC_AW),
        .DST_AW   (DST_AW),
        .CW       (CW),
        .DST_BASE (DST_BASE)
    ) u_pipe (
        .clk      (I_CLK),
        .rst_n    (I_RST_n),
        .clr      (clr),
        .rd_en    (rd_en),
        .src_base (I_SRC_BASE),
        .src_q    (I_SRC_Q),
        .rd_cnt   (rd_cnt),
        .src_ce   (O_SRC_CE),
        .src_addr (O_SRC_ADDR),
        .dst_ce   (O_DST_CE),
        .dst_we   (O_DST_WE),
        .dst_addr (O_DST_ADDR),
        .dst_d    (O_DST_D)
    );

endmodule

// File: tb/tb_obj_dma_ctrl.sv
// Bench for obj_dma_ctrl: three instances (LEN 384, 32, 1) sharing behavioural
// work-RAM and object-RAM models; sel picks which instance owns the memories.
module tb_obj_dma_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go [3];
    logic [9:0] src_base;
    logic       busak [3];
    logic [7:0] src_q;
    logic       busrq [3], grant [3], src_ce [3], dst_ce [3], dst_we [3], busy [3], done [3];
    logic [9:0] src_addr [3];
    logic [8:0] dst_addr [3];
    logic [7:0] dst_d [3];

    int         sel = 0;
    int         ak_dly = 0;
    logic       ak_block = 1'b0;
    logic [2:0] rq_sh = '0;
    logic       ak_src;

    logic [7:0] wram [1024];
    logic [7:0] oram [512];
    logic [9:0] src_log [1024];

    int n_rd = 0, n_we = 0, n_done = 0, n_busy = 0, n_badce = 0;
    int n_chk = 0, n_err = 0;
    int rd0, we0, dn0, bz0, bc0;

    always #5 clk = ~clk;

    // BUSAK follows BUSRQ through ak_dly flops (0 = tied high), forced low by ak_block.
    always @(posedge clk) rq_sh <= {rq_sh[1:0], busrq[sel]};
    assign ak_src = ~ak_block & ((ak_dly == 0) ? 1'b1 : rq_sh[ak_dly-1]);

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign busak[g] = (sel == g) ? ak_src : 1'b0;
        obj_dma_ctrl #(
            .SRC_AW   (10),
            .DST_AW   (9),
            .LEN      ((g == 0) ? 384 : ((g == 1) ? 32 : 1)),
            .DST_BASE (0)
        ) u_dut (
            .I_CLK      (clk),
            .I_RST_n    (rst_n),
            .I_DMA_GO   (go[g]),
            .I_SRC_BASE (src_base),
            .I_BUSAK    (busak[g]),
            .O_BUSRQ    (busrq[g]),
            .O_GRANT    (grant[g]),
            .O_SRC_ADDR (src_addr[g]),
            .O_SRC_CE   (src_ce[g]),
            .I_SRC_Q    (src_q),
            .O_DST_ADDR (dst_addr[g]),
            .O_DST_D    (dst_d[g]),
            .O_DST_CE   (dst_ce[g]),
            .O_DST_WE   (dst_we[g]),
            .O_BUSY     (busy[g]),
            .O_DONE     (done[g])
        );
    end

    always @(posedge clk) begin
        if (src_ce[sel]) src_q <= wram[src_addr[sel]];
        if (dst_ce[sel] && dst_we[sel]) oram[dst_addr[sel]] <= dst_d[sel];
    end

    always @(negedge clk) begin
        if (src_ce[sel]) begin
            src_log[n_rd % 1024] <= src_addr[sel];
            n_rd <= n_rd + 1;
        end
        if (dst_ce[sel] && dst_we[sel]) n_we <= n_we + 1;
        if (done[sel]) n_done <= n_done + 1;
        if (busy[sel]) n_busy <= n_busy + 1;
        if (src_ce[sel] && !grant[sel]) n_badce <= n_badce + 1;
    end

    function automatic logic [7:0] wdat(input int a);
        return 8'(a - 'h100) ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        rd0 = n_rd; we0 = n_we; dn0 = n_done; bz0 = n_busy; bc0 = n_badce;
    endtask

    // Wait at negedges for DONE; lat counts cycles after the GO cycle.
    task automatic wait_done(input int s, output int lat);
        for (lat = 1; lat <= 2000; lat++) begin
            @(posedge clk); #1 go[s] = 1'b0;
            @(negedge clk);
            if (done[s]) break;
        end
    endtask

    task automatic post_checks(input string tag, input int base, input int len, input int nd);
        int bad_c, bad_a;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_writes"}, n_we - we0, len);
        chk({tag, "_reads"}, n_rd - rd0, len);
        chk({tag, "_dones"}, n_done - dn0, nd);
        chk({tag, "_ce_wo_grant"}, n_badce - bc0, 0);
        bad_c = 0; bad_a = 0;
        for (int i = 0; i < len; i++) begin
            if (oram[i] !== wdat((base + i) % 1024)) bad_c++;
            if (src_log[(rd0 + i) % 1024] !== 10'((base + i) % 1024)) bad_a++;
        end
        chk({tag, "_content_bad"}, bad_c, 0);
        chk({tag, "_srcaddr_bad"}, bad_a, 0);
    endtask

    task automatic run_job(input string tag, input int s, input int base, input int d,
                           input int len, input int exp_busy);
        int lat;
        sel = s; ak_dly = d; ak_block = 1'b0;
        repeat (4) @(posedge clk);
        snap();
        #1 go[s] = 1'b1; src_base = 10'(base);
        wait_done(s, lat);
        chk({tag, "_done_lat"}, lat, exp_busy + 1);
        chk({tag, "_busy_cycles"}, n_busy - bz0, exp_busy);
        post_checks(tag, base, len, 1);
    endtask

    typedef struct {
        int sel;
        int base;
        int dly;
        int len;
        int busy;
    } job_t;

    job_t jobs [5];

    initial begin
        int cnt, lat;
        // busy = LEN + 2 + BUSAK delay; DONE follows one cycle later
        jobs[0] = '{0, 'h100, 2, 384, 388};
        jobs[1] = '{0, 'h100, 0, 384, 386};
        jobs[2] = '{1, 'h3F0, 1, 32, 35};
        jobs[3] = '{2, 'h155, 0, 1, 3};
        jobs[4] = '{1, 'h000, 3, 32, 37};

        for (int i = 0; i < 3; i++) go[i] = 1'b0;
        src_base = '0;
        for (int a = 0; a < 1024; a++) wram[a] = wdat(a);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl_outs", {busrq[0], grant[0], src_ce[0], dst_ce[0], dst_we[0], busy[0], done[0]}, 0);
        chk("rst_src_addr", src_addr[0], 0);
        chk("rst_dst_addr", dst_addr[0], 0);
        chk("rst_dst_d", dst_d[0], 0);
        @(negedge clk) rst_n = 1'b1;

        for (int j = 0; j < 5; j++)
            run_job($sformatf("job%0d", j), jobs[j].sel, jobs[j].base, jobs[j].dly,
                    jobs[j].len, jobs[j].busy);

        // Pause: BUSAK drops for 7 cycles right after read 100
        sel = 0; ak_dly = 0; ak_block = 1'b0;
        repeat (2) @(posedge clk);
        snap();
        #1 go[0] = 1'b1; src_base = 10'h100;
        @(posedge clk); #1 go[0] = 1'b0;
        cnt = 0;
        for (int t = 0; t < 2000 && cnt < 100; t++) begin
            @(negedge clk);
            if (src_ce[0]) cnt++;
        end
        chk("pause_reads_seen", cnt, 100);
        @(posedge clk); #1 ak_block = 1'b1;
        @(negedge clk);
        chk("pause_w100_we", dst_we[0], 1);
        chk("pause_w100_addr", dst_addr[0], 99);
        chk("pause_w100_data", dst_d[0], wdat('h100 + 99));
        chk("pause_no_read", src_ce[0], 0);
        chk("pause_grant_hold", grant[0], 1);
        @(negedge clk);
        chk("pause_grant_low", grant[0], 0);
        chk("pause_no_write", dst_we[0], 0);
        chk("pause_busrq_held", busrq[0], 1);
        repeat (6) @(posedge clk);
        #1 ak_block = 1'b0;
        wait_done(0, lat);
        chk("pause_done_seen", done[0], 1);
        post_checks("pause", 'h100, 384, 1);

        // Retrigger: GO in REQ, in XFER and on the DONE cycle is ignored
        sel = 1; ak_dly = 2;
        repeat (4) @(posedge clk);
        snap();
        #1 go[1] = 1'b1; src_base = 10'h200;
        @(posedge clk); #1 go[1] = 1'b1; src_base = 10'h050;
        @(negedge clk);
        chk("rt_in_req", {busrq[1], grant[1]}, 2);
        @(posedge clk); #1 go[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1 go[1] = 1'b1; src_base = 10'h077;
        @(negedge clk);
        chk("rt_in_xfer", grant[1], 1);
        for (int t = 0; t < 200; t++) begin
            @(posedge clk); #1 go[1] = 1'b0;
            @(negedge clk);
            if (done[1]) break;
        end
        chk("rt_done_seen", done[1], 1);
        go[1] = 1'b1; src_base = 10'h0AA;
        @(posedge clk); #1 go[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rt_no_restart", {busy[1], busrq[1]}, 0);
        post_checks("rt", 'h200, 32, 1);

        // Reset at byte 50, then a clean copy from a new base
        sel = 0; ak_dly = 0;
        repeat (2) @(posedge clk);
        snap();
        #1 go[0] = 1'b1; src_base = 10'h100;
        @(posedge clk); #1 go[0] = 1'b0;
        cnt = 0;
        for (int t = 0; t < 2000 && cnt < 50; t++) begin
            @(negedge clk);
            if (src_ce[0]) cnt++;
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {busrq[0], grant[0], src_ce[0], dst_ce[0], dst_we[0], busy[0], done[0]}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_done", n_done - dn0, 0);
        @(negedge clk) rst_n = 1'b1;
        run_job("after_rst", 0, 'h180, 0, 384, 386);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
